// File: rtl/icmp_reply_sched.sv
// ICMP echo reply scheduler: finalises the reply checksum, queues reply descriptors
// and round-robins the shared GMII transmit engine between ICMP replies and video.
module icmp_reply_sched #(
    parameter int DEPTH_LOG2 = 2,
    parameter int MAX_LEN    = 1472
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  gmii_rx_dv,
    input  logic                  rec_pkt_done,
    input  logic [15:0]           rec_byte_num,
    input  logic [15:0]           icmp_id,
    input  logic [15:0]           icmp_seq,
    input  logic [31:0]           reply_checksum,
    output logic [DEPTH_LOG2-1:0] rx_slot,
    output logic                  rx_slot_ok,
    input  logic                  video_tx_req,
    output logic                  video_tx_gnt,
    output logic                  icmp_tx_start,
    output logic [15:0]           icmp_tx_id,
    output logic [15:0]           icmp_tx_seq,
    output logic [15:0]           icmp_tx_len,
    output logic [15:0]           icmp_tx_cksum,
    output logic [DEPTH_LOG2-1:0] icmp_tx_slot,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic [7:0]            drop_cnt
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    typedef enum logic [2:0] {
        R_IDLE, R_WAIT_END, R_WAIT_CK, R_SUM, R_FOLD1, R_FOLD2, R_PUSH
    } rx_state_e;

    typedef enum logic [1:0] {
        T_IDLE, T_ICMP, T_VIDEO
    } tx_state_e;

    typedef struct packed {
        logic [15:0] id;
        logic [15:0] seq;
        logic [15:0] len;
        logic [15:0] cksum;
    } desc_t;

    rx_state_e           rx_state_q, rx_state_d;
    tx_state_e           tx_state_q, tx_state_d;
    logic [15:0]         id_q, id_d;
    logic [15:0]         seq_q, seq_d;
    logic [15:0]         len_q, len_d;
    logic [31:0]         sum32_q, sum32_d;
    logic [16:0]         f1_q, f1_d;
    logic [15:0]         f2_q, f2_d;
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                last_icmp_q, last_icmp_d;
    logic                icmp_tx_start_q, icmp_tx_start_d;

    logic  push, pop, drop, full, empty;
    desc_t mem [DEPTH];
    desc_t head;

    // Extra pointer MSB distinguishes full from empty when the slot bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

    // Each checksum step registers its result on the edge that enters the state named after it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        rx_state_d = rx_state_q;
        id_d       = id_q;
        seq_d      = seq_q;
        len_d      = len_q;
        sum32_d    = sum32_q;
        f1_d       = f1_q;
        f2_d       = f2_q;
        push       = 1'b0;
        drop       = rec_pkt_done && (rx_state_q != R_IDLE);
        unique case (rx_state_q)
            R_IDLE: begin
                if (rec_pkt_done) begin
                    id_d  = icmp_id;
                    seq_d = icmp_seq;
                    len_d = rec_byte_num;
                    if (rec_byte_num > MAX_LEN_W || rec_byte_num == 16'h0 || full) begin
                        drop = 1'b1;
                    end else begin
                        rx_state_d = R_WAIT_END;
                    end
                end
            end
            R_WAIT_END: if (!gmii_rx_dv) rx_state_d = R_WAIT_CK;
            R_WAIT_CK: begin
                sum32_d    = reply_checksum + {16'h0, id_q} + {16'h0, seq_q};
                rx_state_d = R_SUM;
            end
            R_SUM: begin
                f1_d       = {1'b0, sum32_q[31:16]} + {1'b0, sum32_q[15:0]};
                rx_state_d = R_FOLD1;
            end
            R_FOLD1: begin
                f2_d       = f1_q[15:0] + {15'h0, f1_q[16]};
                rx_state_d = R_FOLD2;
            end
            R_FOLD2: begin
                push       = 1'b1;
                rx_state_d = R_PUSH;
            end
            R_PUSH:  rx_state_d = R_IDLE;
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d      = tx_state_q;
        last_icmp_d     = last_icmp_q;
        icmp_tx_start_d = 1'b0;
        pop             = 1'b0;
        unique case (tx_state_q)
            T_IDLE: begin
                if (!tx_busy) begin
                    if (!empty && (!video_tx_req || !last_icmp_q)) begin
                        icmp_tx_start_d = 1'b1;
                        tx_state_d      = T_ICMP;
                    end else if (video_tx_req) begin
                        tx_state_d = T_VIDEO;
                    end
                end
            end
            T_ICMP: begin
                if (tx_done) begin
                    pop         = 1'b1;
                    last_icmp_d = 1'b1;
                    tx_state_d  = T_IDLE;
                end
            end
            T_VIDEO: begin
                if (tx_done) begin
                    last_icmp_d = 1'b0;
                    tx_state_d  = T_IDLE;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (DEPTH_LOG2+1)'(push);
        rd_ptr_d   = rd_ptr_q + (DEPTH_LOG2+1)'(pop);
        drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q      <= R_IDLE;
            tx_state_q      <= T_IDLE;
            id_q            <= '0;
            seq_q           <= '0;
            len_q           <= '0;
            sum32_q         <= '0;
            f1_q            <= '0;
            f2_q            <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            drop_cnt_q      <= '0;
            last_icmp_q     <= 1'b0;
            icmp_tx_start_q <= 1'b0;
        end else begin
            rx_state_q      <= rx_state_d;
            tx_state_q      <= tx_state_d;
            id_q            <= id_d;
            seq_q           <= seq_d;
            len_q           <= len_d;
            sum32_q         <= sum32_d;
            f1_q            <= f1_d;
            f2_q            <= f2_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            drop_cnt_q      <= drop_cnt_d;
            last_icmp_q     <= last_icmp_d;
            icmp_tx_start_q <= icmp_tx_start_d;
        end
    end

    // NOTE: descriptor storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= '{id: id_q, seq: seq_q, len: len_q, cksum: ~f2_q};
    end

    // An empty queue presents zeros so the head outputs are defined straight out of reset.
    assign head = empty ? '0 : mem[rd_ptr_q[DEPTH_LOG2-1:0]];

    assign rx_slot       = wr_ptr_q[DEPTH_LOG2-1:0];
    assign rx_slot_ok    = !full;
    assign video_tx_gnt  = (tx_state_q == T_VIDEO);
    assign icmp_tx_start = icmp_tx_start_q;
    assign icmp_tx_id    = head.id;
    assign icmp_tx_seq   = head.seq;
    assign icmp_tx_len   = head.len;
    assign icmp_tx_cksum = head.cksum;
    assign icmp_tx_slot  = rd_ptr_q[DEPTH_LOG2-1:0];
    assign drop_cnt      = drop_cnt_q;

endmodule
